decoder_3to8_seq: RTL

DECODER_3TO8_SEQ -- requirements
Module: decoder_3to8_seq

---
 rtl/decoder_3to8_seq.sv | 121 ++++++++++++
 1 files changed

// File: rtl/decoder_3to8_seq.sv
// Sequenced 3:8 decoder: accepts an index when idle, drives the one-hot line
// until ack or hold timeout, then idles for GAP cycles before accepting again.
module decoder_3to8_seq #(
    parameter int HOLD_MAX = 15,
    parameter int GAP      = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] in,
    input  logic       valid,
    output logic       ready,
    output logic [7:0] out,
    output logic       out_valid,
    input  logic       ack,
    output logic       timeout,
    output logic [7:0] count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_GAP
    } state_t;

    localparam logic [7:0] HOLD_MAX_W = 8'(HOLD_MAX);
    localparam logic [3:0] GAP_W      = 4'(GAP);

    state_t     state, state_nxt;
    logic [7:0] timer, timer_nxt;
    logic [3:0] gap_cnt, gap_cnt_nxt;
    logic [7:0] out_nxt;
    logic       out_valid_nxt;
    logic       ready_nxt;
    logic       timeout_nxt;
    logic [7:0] count_nxt;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_nxt     = state;
        timer_nxt     = timer;
        gap_cnt_nxt   = gap_cnt;
        out_nxt       = out;
        out_valid_nxt = out_valid;
        timeout_nxt   = timeout;
        count_nxt     = count;

        case (state)
            ST_IDLE: begin
                if (valid && ready) begin
                    state_nxt     = ST_DRIVE;
                    out_nxt       = 8'd1 << in;
                    out_valid_nxt = 1'b1;
                    timer_nxt     = 8'd1;
                end
            end

            ST_DRIVE: begin
                // ack is checked first so it wins over a coincident timeout
                if (ack || timer == HOLD_MAX_W) begin
                    if (ack) count_nxt   = count + 8'd1;
                    else     timeout_nxt = 1'b1;
                    out_nxt       = 8'd0;
                    out_valid_nxt = 1'b0;
                    timer_nxt     = 8'd0;
                    if (GAP == 0) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt   = ST_GAP;
                        gap_cnt_nxt = 4'd1;
                    end
                end else begin
                    timer_nxt = timer + 8'd1;
                end
            end

            ST_GAP: begin
                if (gap_cnt == GAP_W) begin
                    state_nxt   = ST_IDLE;
                    gap_cnt_nxt = 4'd0;
                end else begin
                    gap_cnt_nxt = gap_cnt + 4'd1;
                end
            end

            default: begin
                state_nxt     = ST_IDLE;
                timer_nxt     = 8'd0;
                gap_cnt_nxt   = 4'd0;
                out_nxt       = 8'd0;
                out_valid_nxt = 1'b0;
            end
        endcase

        // ready is registered, so it reflects the state being entered
        ready_nxt = (state_nxt == ST_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments; reset is asynchronous so it acts without a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            timer     <= 8'd0;
            gap_cnt   <= 4'd0;
            out       <= 8'd0;
            out_valid <= 1'b0;
            ready     <= 1'b0;
            timeout   <= 1'b0;
            count     <= 8'd0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            gap_cnt   <= gap_cnt_nxt;
            out       <= out_nxt;
            out_valid <= out_valid_nxt;
            ready     <= ready_nxt;
            timeout   <= timeout_nxt;
            count     <= count_nxt;
        end
    end

endmodule
